// File: rtl/count_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_share_ctrl
// Description : Round-robin controller sharing one up-counter between two
//               requesters. The granted requester's terminal value is latched,
//               the counter is cleared, counted up to that value (pausable via
//               hold), a one-cycle done is pulsed, then the counter is freed.
// Revision    : 1.0 - initial release
// ============================================================================
module count_share_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] tgt0,
    input  logic [WIDTH-1:0] tgt1,
    input  logic             hold,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_nxt;
    logic             r_sel;        // requester owning the current job
    logic             w_sel_nxt;
    logic             r_ptr;        // round-robin preference when both request
    logic             w_ptr_nxt;
    logic [1:0]       r_gnt;
    logic [1:0]       w_gnt_nxt;
    logic [1:0]       r_done;
    logic [1:0]       w_done_nxt;
    logic             r_busy;
    logic             w_pick;

    // Winner of an IDLE-cycle arbitration: pointer breaks ties, otherwise
    // whichever single requester is active.
    assign w_pick = (req0 && req1) ? r_ptr : req1;

    // Next-state and next-output decode; every output is registered below so
    // nothing here reaches a port combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_sel_nxt    = w_pick;
                    w_target_nxt = w_pick ? tgt1 : tgt0;
                    w_gnt_nxt    = w_pick ? 2'b10 : 2'b01;
                    w_state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // hold has no effect here; the clear always happens
                w_count_nxt = c_zero;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // hold wins even at terminal count, stretching the job
                if (!hold) begin
                    if (r_count == r_target) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = r_gnt;
                    end else begin
                        w_count_nxt = r_count + c_one;
                    end
                end
            end
            ST_DONE: begin
                // count keeps the final value until the next job clears it
                w_gnt_nxt   = 2'b00;
                w_ptr_nxt   = ~r_sel;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers; reset aborts any job without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= c_zero;
            r_target <= c_zero;
            r_sel    <= 1'b0;
            r_ptr    <= 1'b0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_busy   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_sel    <= w_sel_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

    assign gnt0  = r_gnt[0];
    assign gnt1  = r_gnt[1];
    assign done0 = r_done[0];
    assign done1 = r_done[1];
    assign busy  = r_busy;
    assign count = r_count;

endmodule
`default_nettype wire

// File: doc/count_share_ctrl.md
# count_share_ctrl

Controller and round-robin arbiter that shares one 3-bit up-counter datapath between two requesters. A granted requester supplies a terminal value. The block clears the counter, counts it up to that value (pausable), pulses a per-requester done, then releases the counter. It sits between requesting control logic and the counter it owns internally, exposing the live count.

## Interface
- WIDTH, 3, counter width; targets and count are WIDTH bits
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- req0, req1  input  1 each  level request; holder keeps it high until its done
- tgt0, tgt1  input  WIDTH each  terminal count, sampled only at grant
- hold  input  1  pauses counting while high (RUN state only)
- gnt0, gnt1  output  1 each  registered grant; at most one high
- done0, done1  output  1 each  one-cycle completion pulse to the granted requester
- busy  output  1  high whenever state != IDLE
- count  output  WIDTH  counter datapath value

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset places the block in IDLE with count=0, all gnt/done=0, busy=0, rr pointer=0 (requester 0 preferred).
- IDLE:
  - No req: stay in IDLE; count keeps its last value.
  - Exactly one req: grant that requester.
  - Both req: grant the requester named by the rr pointer.
  - On grant: latch that requester's tgt into an internal target register, set its gnt, go to LOAD.
- LOAD: count <= 0; go to RUN. hold is ignored in LOAD.
- RUN, evaluated in priority order:
  - hold=1: count and state unchanged. This applies even when count==target.
  - count==target: go to DONE.
  - Otherwise: count <= count+1.
- DONE: assert done of the granted requester for this single cycle, with gnt still high. On the next edge: clear gnt, set rr pointer to the other requester, go to IDLE.
- Width rules: target ≤ 2^WIDTH−1, and counting stops at target, so count never wraps. For target 7, count goes 0..7 and then holds at 7.
- After completion, count holds the final target until the next LOAD.
- Granted job ignores changes to its tgt and any drop of its req; the job always runs to completion. A requester that keeps req high after its done re-competes in the next IDLE cycle.
- Ungranted req is ignored while busy.
- Asynchronous rst at any time, including mid-RUN: immediately force IDLE, count=0, gnt/done/busy=0, pointer=0. No done is issued for the aborted job.

## Timing
- Request sampled at edge E0 → gnt and busy high after E0 (state LOAD).
- count=0 after E1.
- With target T and no hold: count==T after E(1+T); done high in the cycle after E(2+T); gnt, done and busy low after E(3+T).
- Grant-to-done latency is T+2 cycles. Each hold cycle adds exactly one cycle.
- At least one IDLE cycle separates consecutive jobs. The next grant occurs at E(4+T) at the earliest.
- gnt, done, busy and count are all registered outputs, with no combinational path from inputs.

## Test plan
- Reset: assert rst mid-cycle with clk stopped → count=0, gnt0/gnt1/done0/done1/busy=0 immediately (asynchronous).
- Single requester: req0=1, tgt0=5 at E0 → gnt0 after E0; count 0,1,2,3,4,5 after E1..E6; done0 pulse after E7; gnt0=0, busy=0 after E8; count stays 5.
- Contention and round-robin: req0=req1=1 from reset, tgt0=2, tgt1=3 → gnt0 first, done0, one IDLE cycle, then gnt1 with count 0..3 and done1. A third job with both still requesting goes to requester 0.
- Target 0 and target 7: tgt1=0 → count=0, done1 one cycle after RUN entry (latency 2). tgt0=7 → count reaches 7, done0, count stays 7, no wrap to 0.
- Hold: tgt0=4, hold=1 for 3 cycles while count=2, and again for 2 cycles while count=4 → count frozen in both windows; done0 delayed by exactly 5 cycles vs. no-hold.
- Reset mid-operation: tgt1=6, assert rst when count=3 → immediate return to reset values, no done1. With req0=req1=1 after release, gnt0 is granted first (pointer reset to 0).
